// File: rtl/tw_sched_pkg.sv
// Shared constants and state codes for the twiddle ROM scheduler and the twiddle ROM.
package tw_sched_pkg;

  localparam int SC_WIDTH  = 3;
  localparam int S_WIDTH   = 4;
  localparam int LOAD_ROWS = 4;
  localparam int GAP_CYC   = 2;

  localparam int BEAT_W = 8;
  localparam int ROW_W  = 2;

  localparam logic [ROW_W-1:0] ROW_TC = ROW_W'(LOAD_ROWS - 1);
  localparam logic [ROW_W-1:0] GAP_TC = ROW_W'(GAP_CYC - 1);

  typedef enum logic [S_WIDTH-1:0] {
    IDLE     = S_WIDTH'(0),
    LOAD_HI  = S_WIDTH'(1),
    LOAD_LO  = S_WIDTH'(2),
    PREP     = S_WIDTH'(3),
    RUN      = S_WIDTH'(4),
    GAP      = S_WIDTH'(5),
    RUN_LAST = S_WIDTH'(6),
    DONE     = S_WIDTH'(7)
  } state_e;

  typedef enum logic [1:0] {
    W_NONE  = 2'd0,
    W_UPPER = 2'd1,
    W_LOWER = 2'd2
  } rom_w_e;

endpackage

// File: rtl/tw_beat_cnt.sv
// Up-counter with synchronous clear, enable and terminal-count flag; it never counts past tc_val.
module tw_beat_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         at_tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_tc = (cnt_q == tc_val);
  assign cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !at_tc)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tw_rom_sched.sv
// Twiddle ROM scheduler: optional two-phase row load, then per-stage ROM enable windows with gaps.
module tw_rom_sched
  import tw_sched_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                load_en,
  input  logic [SC_WIDTH-1:0] last_stage,
  input  logic [7:0]          run_len,
  input  logic                hold,
  input  logic                abort,
  output logic [SC_WIDTH-1:0] stage_counter,
  output logic [S_WIDTH-1:0]  state,
  output logic                CEN,
  output logic [1:0]          ROM2_w,
  output logic [1:0]          row_sel,
  output logic                busy,
  output logic                done
);

  state_e              st_q, st_d;
  logic [SC_WIDTH-1:0] stage_q, stage_d, stage_inc;
  logic [SC_WIDTH-1:0] last_q;
  logic [BEAT_W-1:0]   len_q;
  logic                load_q, load_d;
  logic                cfg_ld;

  logic                cen_q, cen_d;
  rom_w_e              rom_w_q, rom_w_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                in_run, in_load, in_gap;
  logic                beat_en, beat_clr, beat_tc;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                row_en, row_clr, row_tc;
  logic [ROW_W-1:0]    row_tc_val;
  logic [ROW_W-1:0]    row_cnt;

  assign in_run  = (st_q == RUN) || (st_q == RUN_LAST);
  assign in_load = (st_q == LOAD_HI) || (st_q == LOAD_LO);
  assign in_gap  = (st_q == GAP);

  assign stage_inc = stage_q + SC_WIDTH'(1);

  // Beat counter only advances on un-stalled RUN cycles and is cleared everywhere else.
  assign beat_en  = in_run && !hold;
  assign beat_clr = abort || !in_run || (beat_tc && !hold);

  assign row_en     = in_load || in_gap;
  assign row_tc_val = in_gap ? GAP_TC : ROW_TC;
  assign row_clr    = abort || !row_en || row_tc;

  tw_beat_cnt #(.W(BEAT_W)) u_beat_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (beat_clr),
    .en     (beat_en),
    .tc_val (len_q),
    .cnt    (beat_cnt),
    .at_tc  (beat_tc)
  );

  tw_beat_cnt #(.W(ROW_W)) u_row_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (row_clr),
    .en     (row_en),
    .tc_val (row_tc_val),
    .cnt    (row_cnt),
    .at_tc  (row_tc)
  );

  always_comb begin
    st_d    = st_q;
    stage_d = stage_q;
    cfg_ld  = 1'b0;

    case (st_q)
      IDLE: begin
        if (start && !abort) begin
          cfg_ld = 1'b1;
          st_d   = load_en ? LOAD_HI : PREP;
        end
      end
      LOAD_HI: if (row_tc) st_d = LOAD_LO;
      LOAD_LO: if (row_tc) st_d = PREP;
      PREP: begin
        stage_d = '0;
        st_d    = (last_q == '0) ? RUN_LAST : RUN;
      end
      RUN: if (!hold && beat_tc) st_d = GAP;
      GAP: begin
        if (row_tc) begin
          stage_d = stage_inc;
          st_d    = (stage_inc == last_q) ? RUN_LAST : RUN;
        end
      end
      RUN_LAST: if (!hold && beat_tc) st_d = DONE;
      DONE: begin
        st_d    = IDLE;
        stage_d = '0;
      end
      default: st_d = IDLE;
    endcase

    if (abort && st_q != IDLE) begin
      st_d    = IDLE;
      stage_d = '0;
    end

    load_d = cfg_ld ? load_en : load_q;

    // CEN for the next cycle: low in RUN windows unless this cycle is a stalled RUN cycle.
    cen_d = !(((st_d == RUN) || (st_d == RUN_LAST)) && !(in_run && hold));

    rom_w_d = W_NONE;
    if (load_d) begin
      if (st_d == LOAD_HI)
        rom_w_d = W_UPPER;
      else if (st_d == LOAD_LO)
        rom_w_d = W_LOWER;
    end

    busy_d = (st_d != IDLE);
    done_d = (st_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= IDLE;
      stage_q <= '0;
      last_q  <= '0;
      len_q   <= '0;
      load_q  <= 1'b0;
      cen_q   <= 1'b1;
      rom_w_q <= W_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      stage_q <= stage_d;
      load_q  <= load_d;
      cen_q   <= cen_d;
      rom_w_q <= rom_w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (cfg_ld) begin
        last_q <= last_stage;
        len_q  <= run_len;
      end
    end
  end

  assign state         = st_q;
  assign stage_counter = stage_q;
  assign CEN           = cen_q;
  assign ROM2_w        = rom_w_q;
  assign row_sel       = row_cnt;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_tw_rom_sched.sv
// Directed bench for tw_rom_sched: load phases, stage windows, hold, abort, reset and long runs.
module tb_tw_rom_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       load_en;
  logic [2:0] last_stage;
  logic [7:0] run_len;
  logic       hold;
  logic       abort;
  logic [2:0] stage_counter;
  logic [3:0] state;
  logic       CEN;
  logic [1:0] ROM2_w;
  logic [1:0] row_sel;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_seen = 0;
  int d0, b0;

  tw_rom_sched dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .load_en       (load_en),
    .last_stage    (last_stage),
    .run_len       (run_len),
    .hold          (hold),
    .abort         (abort),
    .stage_counter (stage_counter),
    .state         (state),
    .CEN           (CEN),
    .ROM2_w        (ROM2_w),
    .row_sel       (row_sel),
    .busy          (busy),
    .done          (done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (done === 1'b1) done_seen++;
    if (busy === 1'b1) busy_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // row < 0 skips the row_sel comparison (row_sel carries no meaning in GAP).
  task automatic expo(input string tag, input int st, input int stg, input int cen,
                      input int w, input int row, input int bsy, input int dn);
    chk({tag, ".state"}, 32'(state), st);
    chk({tag, ".stage"}, 32'(stage_counter), stg);
    chk({tag, ".CEN"}, 32'(CEN), cen);
    chk({tag, ".ROM2_w"}, 32'(ROM2_w), w);
    if (row >= 0) chk({tag, ".row_sel"}, 32'(row_sel), row);
    chk({tag, ".busy"}, 32'(busy), bsy);
    chk({tag, ".done"}, 32'(done), dn);
  endtask

  task automatic go(input logic le, input logic [2:0] ls, input logic [7:0] rl);
    start = 1'b1; load_en = le; last_stage = ls; run_len = rl;
    tick();
    start = 1'b0; load_en = 1'b0; last_stage = 3'd0; run_len = 8'd0;
  endtask

  task automatic run_stage(input int st, input int stg, input int beats);
    for (int b = 0; b < beats; b++) begin
      expo("run", st, stg, 0, 0, 0, 1, 0);
      tick();
    end
  endtask

  task automatic gap_cyc(input int stg);
    for (int g = 0; g < 2; g++) begin
      expo("gap", 5, stg, 1, 0, -1, 1, 0);
      tick();
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; load_en = 1'b0; last_stage = 3'd0;
    run_len = 8'd0; hold = 1'b0; abort = 1'b0;
    tick();
    expo("reset", 0, 0, 1, 0, 0, 0, 0);
    RST = 1'b0;
    tick();
    expo("idle0", 0, 0, 1, 0, 0, 0, 0);

    // Test 1: full run with load, three stages of 16 beats
    d0 = done_seen; b0 = busy_seen;
    go(1'b1, 3'd2, 8'd15);
    for (int i = 0; i < 4; i++) begin expo("ldhi", 1, 0, 1, 1, i, 1, 0); tick(); end
    for (int i = 0; i < 4; i++) begin expo("ldlo", 2, 0, 1, 2, i, 1, 0); tick(); end
    expo("t1prep", 3, 0, 1, 0, 0, 1, 0); tick();
    run_stage(4, 0, 16); gap_cyc(0);
    run_stage(4, 1, 16); gap_cyc(1);
    run_stage(6, 2, 16);
    expo("t1done", 7, 2, 1, 0, 0, 1, 1); tick();
    expo("t1idle", 0, 0, 1, 0, 0, 0, 0);
    chk("t1.done_pulses", 32'(done_seen - d0), 1);
    chk("t1.busy_cycles", 32'(busy_seen - b0), 62);

    // Test 2: no load, single stage of 4 beats
    d0 = done_seen;
    go(1'b0, 3'd0, 8'd3);
    expo("t2prep", 3, 0, 1, 0, 0, 1, 0); tick();
    run_stage(6, 0, 4);
    expo("t2done", 7, 0, 1, 0, 0, 1, 1); tick();
    expo("t2idle", 0, 0, 1, 0, 0, 0, 0);
    chk("t2.done_pulses", 32'(done_seen - d0), 1);

    // Test 3: hold for 5 cycles at beat 7 of stage 1
    go(1'b0, 3'd2, 8'd15);
    expo("t3prep", 3, 0, 1, 0, 0, 1, 0); tick();
    run_stage(4, 0, 16); gap_cyc(0);
    run_stage(4, 1, 7);
    expo("t3beat7", 4, 1, 0, 0, 0, 1, 0);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      expo("t3hold", 4, 1, 1, 0, 0, 1, 0);
    end
    hold = 1'b0;
    tick();
    run_stage(4, 1, 8);
    gap_cyc(1);
    run_stage(6, 2, 16);
    expo("t3done", 7, 2, 1, 0, 0, 1, 1); tick();
    expo("t3idle", 0, 0, 1, 0, 0, 0, 0);

    // Test 4: abort at beat 10 of stage 1
    d0 = done_seen;
    go(1'b0, 3'd2, 8'd15);
    expo("t4prep", 3, 0, 1, 0, 0, 1, 0); tick();
    run_stage(4, 0, 16); gap_cyc(0);
    run_stage(4, 1, 10);
    expo("t4beat10", 4, 1, 0, 0, 0, 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expo("t4abort", 0, 0, 1, 0, 0, 0, 0);
    tick();
    expo("t4idle", 0, 0, 1, 0, 0, 0, 0);
    chk("t4.done_pulses", 32'(done_seen - d0), 0);

    // start together with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1; load_en = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0; load_en = 1'b0;
    expo("stabort", 0, 0, 1, 0, 0, 0, 0);

    // Test 5: reset during LOAD_LO, then a normal run
    go(1'b1, 3'd1, 8'd2);
    for (int i = 0; i < 4; i++) begin expo("t5ldhi", 1, 0, 1, 1, i, 1, 0); tick(); end
    for (int i = 0; i < 2; i++) begin expo("t5ldlo", 2, 0, 1, 2, i, 1, 0); tick(); end
    expo("t5ldlo2", 2, 0, 1, 2, 2, 1, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    expo("t5reset", 0, 0, 1, 0, 0, 0, 0);
    go(1'b0, 3'd1, 8'd2);
    expo("t5prep", 3, 0, 1, 0, 0, 1, 0); tick();
    run_stage(4, 0, 3); gap_cyc(0);
    run_stage(6, 1, 3);
    expo("t5done", 7, 1, 1, 0, 0, 1, 1); tick();
    expo("t5idle", 0, 0, 1, 0, 0, 0, 0);

    // Test 6: 256 beats, stray start pulses in RUN_LAST and DONE
    d0 = done_seen;
    go(1'b0, 3'd0, 8'd255);
    expo("t6prep", 3, 0, 1, 0, 0, 1, 0); tick();
    for (int b = 0; b < 256; b++) begin
      expo("t6run", 6, 0, 0, 0, 0, 1, 0);
      if (b == 100) begin start = 1'b1; load_en = 1'b1; last_stage = 3'd3; run_len = 8'd0; end
      tick();
      if (b == 100) begin start = 1'b0; load_en = 1'b0; last_stage = 3'd0; end
    end
    expo("t6done", 7, 0, 1, 0, 0, 1, 1);
    start = 1'b1; load_en = 1'b1;
    tick();
    start = 1'b0; load_en = 1'b0;
    expo("t6idle", 0, 0, 1, 0, 0, 0, 0);
    tick();
    expo("t6idle2", 0, 0, 1, 0, 0, 0, 0);
    chk("t6.done_pulses", 32'(done_seen - d0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
